// File: rtl/fp_result_round_pack.sv
// fp_result_round_pack
//   Rounds (nearest-even), re-normalises, applies special-case overrides,
//   classifies exceptions and packs an IEEE-754 style result word.
//   Two registered stages (S1 round, S2 override/classify/pack) behind an
//   elastic valid/ready handshake, plus sticky RISC-V style fflags.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   sign_i, exp_i, sig_i  sign, biased exponent, {hidden, mantissa, rounding bits}
//   nz_op_i               non-zero operand {exp, man} returned for ZERO_OP
//   err_i                 special code: 0 NONE, 1 ZERO_OP, 2 INF, 3 NAN, 4 ZERO
//   out_valid / out_ready output beat handshake
//   fp_o                  packed result {sign, exp, man}
//   err_o                 0 NONE, 1 INVALID, 3 OVERFLOW, 4 UNDERFLOW, 5 INEXACT
//   flags_clr             clear sticky flags
//   flags_o               sticky {NV, DZ, OF, UF, NX}; DZ is always 0
module fp_result_round_pack #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int RND_BITS = 3,
    parameter int OVF_SAT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        sign_i,
    input  logic [EXP_W-1:0]            exp_i,
    input  logic [MAN_W+RND_BITS:0]     sig_i,
    input  logic [EXP_W+MAN_W-1:0]      nz_op_i,
    input  logic [2:0]                  err_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+MAN_W:0]        fp_o,
    output logic [2:0]                  err_o,
    input  logic                        flags_clr,
    output logic [4:0]                  flags_o
);

    localparam int SIG_W = 1 + MAN_W + RND_BITS;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ZERO_OP = 3'd1;
    localparam logic [2:0] ERR_INF     = 3'd2;
    localparam logic [2:0] ERR_NAN     = 3'd3;
    localparam logic [2:0] ERR_ZERO    = 3'd4;

    localparam logic [2:0] EXC_NONE      = 3'd0;
    localparam logic [2:0] EXC_INVALID   = 3'd1;
    localparam logic [2:0] EXC_OVERFLOW  = 3'd3;
    localparam logic [2:0] EXC_UNDERFLOW = 3'd4;
    localparam logic [2:0] EXC_INEXACT   = 3'd5;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] MAN_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv;
    logic accept;
    logic xfer;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    // ---------------------------------------------------------------
    // S1: round to nearest even
    // ---------------------------------------------------------------
    logic             rnd_lsb, rnd_g, rnd_s, rnd_inc;
    logic [MAN_W+1:0] m_sum;
    logic [EXP_W:0]   e_rnd;
    logic [MAN_W-1:0] m_rnd;
    logic             ovf_rnd;

    always_comb begin
        rnd_lsb = sig_i[RND_BITS];
        rnd_g   = sig_i[RND_BITS-1];
        rnd_s   = |sig_i[RND_BITS-2:0];
        rnd_inc = rnd_g & (rnd_s | rnd_lsb);
        // One guard bit above the hidden bit keeps the rounding carry.
        m_sum   = {1'b0, sig_i[SIG_W-1:RND_BITS]} + {{(MAN_W+1){1'b0}}, rnd_inc};
        e_rnd   = {1'b0, exp_i};
        m_rnd   = m_sum[MAN_W-1:0];
        if (m_sum[MAN_W+1]) begin
            m_rnd = m_sum[MAN_W:1];
            e_rnd = {1'b0, exp_i} + {{EXP_W{1'b0}}, 1'b1};
        end else if ((exp_i == '0) && m_sum[MAN_W]) begin
            // Denormal rounded up into the smallest normal.
            e_rnd = {{EXP_W{1'b0}}, 1'b1};
        end
        ovf_rnd = (e_rnd >= {1'b0, EXP_ONES}) && (err_i == ERR_NONE);
    end

    logic                   s1_sign_q, s1_sign_d;
    logic [2:0]             s1_err_q, s1_err_d;
    logic [EXP_W-1:0]       s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0]       s1_man_q, s1_man_d;
    logic                   s1_ovf_q, s1_ovf_d;
    logic                   s1_nx_q, s1_nx_d;
    logic [EXP_W+MAN_W-1:0] s1_nz_q, s1_nz_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_err_d   = s1_err_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_ovf_d   = s1_ovf_q;
        s1_nx_d    = s1_nx_q;
        s1_nz_d    = s1_nz_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_sign_d = sign_i;
            s1_err_d  = err_i;
            s1_exp_d  = e_rnd[EXP_W-1:0];
            s1_man_d  = m_rnd;
            s1_ovf_d  = ovf_rnd;
            s1_nx_d   = rnd_g | rnd_s;
            s1_nz_d   = nz_op_i;
        end
    end

    // ---------------------------------------------------------------
    // S2: override, classify, pack
    // ---------------------------------------------------------------
    logic [FP_W-1:0] pk_fp;
    logic            pk_nv, pk_of, pk_uf, pk_nx;
    logic [2:0]      pk_err;

    always_comb begin
        pk_fp = '0;
        pk_nv = 1'b0;
        pk_of = 1'b0;
        pk_uf = 1'b0;
        pk_nx = 1'b0;
        case (s1_err_q)
            ERR_NONE: begin
                if (s1_ovf_q) begin
                    if (OVF_SAT != 0) pk_fp = {s1_sign_q, EXP_MAXF, MAN_ONES};
                    else              pk_fp = {s1_sign_q, EXP_ONES, MAN_ZERO};
                    pk_of = 1'b1;
                end else begin
                    pk_fp = {s1_sign_q, s1_exp_q, s1_man_q};
                    pk_uf = (s1_exp_q == '0) && (s1_man_q != '0);
                end
                pk_nx = s1_nx_q | s1_ovf_q;
            end
            ERR_ZERO_OP: pk_fp = {s1_sign_q, s1_nz_q};
            ERR_INF: begin
                pk_fp = {s1_sign_q, EXP_ONES, MAN_ZERO};
                pk_of = 1'b1;
            end
            ERR_NAN: begin
                pk_fp = {1'b0, EXP_ONES, MAN_ONES};
                pk_nv = 1'b1;
            end
            ERR_ZERO: pk_fp = '0;
            // Unassigned codes pack as +0 with no exception.
            default:  pk_fp = '0;
        endcase

        if (pk_nv)      pk_err = EXC_INVALID;
        else if (pk_of) pk_err = EXC_OVERFLOW;
        else if (pk_uf) pk_err = EXC_UNDERFLOW;
        else if (pk_nx) pk_err = EXC_INEXACT;
        else            pk_err = EXC_NONE;
    end

    logic [FP_W-1:0] fp_q, fp_d;
    logic [2:0]      err_q, err_d;
    logic [4:0]      beat_flags_q, beat_flags_d;
    logic [4:0]      flags_q, flags_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        fp_d         = fp_q;
        err_d        = err_q;
        beat_flags_d = beat_flags_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                fp_d         = pk_fp;
                err_d        = pk_err;
                beat_flags_d = {pk_nv, 1'b0, pk_of, pk_uf, pk_nx};
            end
        end
        // A clear coinciding with a transfer still keeps that beat's flags.
        flags_d = (flags_clr ? 5'b0 : flags_q) | (xfer ? beat_flags_q : 5'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_err_q     <= ERR_NONE;
            s1_exp_q     <= '0;
            s1_man_q     <= '0;
            s1_ovf_q     <= 1'b0;
            s1_nx_q      <= 1'b0;
            s1_nz_q      <= '0;
            out_valid_q  <= 1'b0;
            fp_q         <= '0;
            err_q        <= EXC_NONE;
            beat_flags_q <= '0;
            flags_q      <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_err_q     <= s1_err_d;
            s1_exp_q     <= s1_exp_d;
            s1_man_q     <= s1_man_d;
            s1_ovf_q     <= s1_ovf_d;
            s1_nx_q      <= s1_nx_d;
            s1_nz_q      <= s1_nz_d;
            out_valid_q  <= out_valid_d;
            fp_q         <= fp_d;
            err_q        <= err_d;
            beat_flags_q <= beat_flags_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign fp_o      = fp_q;
    assign err_o     = err_q;
    assign flags_o   = flags_q;

endmodule

// File: tb/tb_fp_result_round_pack.sv
// Testbench for fp_result_round_pack (binary32 configuration).
// Two instances share all inputs: one with OVF_SAT=0, one with OVF_SAT=1.
// Expected results are pushed to a scoreboard at accept and compared at
// output transfer; directed checks use constant reference values.
module tb_fp_result_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sign_i;
    logic [7:0]  exp_i;
    logic [26:0] sig_i;
    logic [30:0] nz_op_i;
    logic [2:0]  err_i;
    logic        out_ready;
    logic        flags_clr;

    logic        in_ready, out_valid;
    logic [31:0] fp_o;
    logic [2:0]  err_o;
    logic [4:0]  flags_o;

    logic        in_ready_s, out_valid_s;
    logic [31:0] fp_s;
    logic [2:0]  err_s;
    logic [4:0]  flags_s;

    always #5 clk = ~clk;

    fp_result_round_pack #(.EXP_W(8), .MAN_W(23), .RND_BITS(3), .OVF_SAT(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .nz_op_i(nz_op_i), .err_i(err_i),
        .out_valid(out_valid), .out_ready(out_ready), .fp_o(fp_o), .err_o(err_o),
        .flags_clr(flags_clr), .flags_o(flags_o)
    );

    fp_result_round_pack #(.EXP_W(8), .MAN_W(23), .RND_BITS(3), .OVF_SAT(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .sign_i(sign_i), .exp_i(exp_i), .sig_i(sig_i), .nz_op_i(nz_op_i), .err_i(err_i),
        .out_valid(out_valid_s), .out_ready(out_ready), .fp_o(fp_s), .err_o(err_s),
        .flags_clr(flags_clr), .flags_o(flags_s)
    );

    typedef struct {
        logic [31:0] fp;
        logic [31:0] fp_sat;
        logic [2:0]  ec;
        logic [4:0]  fl;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad = 0;
    int         acc_cnt = 0;
    int         xfer_cnt = 0;
    logic [4:0] mflags = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic sg, input logic [7:0] ex, input logic [26:0] sig,
                                   input logic [30:0] nz, input logic [2:0] er);
        exp_t        r;
        int unsigned man;
        int unsigned e;
        logic        g, s, l, nx, ovf, uf;
        logic [22:0] mf;
        logic [7:0]  e8;
        man = 32'(sig[26:3]);
        l   = sig[3];
        g   = sig[2];
        s   = sig[1] | sig[0];
        nx  = g | s;
        if (g && (s || l)) man = man + 1;
        e = 32'(ex);
        if (man >= 32'h0100_0000) begin
            man = man >> 1;
            e   = e + 1;
        end else if (ex == 8'd0 && man >= 32'h0080_0000) begin
            e = 1;
        end
        ovf = (e >= 255);
        mf  = man[22:0];
        e8  = e[7:0];
        r.fp = 32'h0;
        r.fl = 5'b0;
        case (er)
            3'd0: begin
                if (ovf) begin
                    r.fp = {sg, 8'hFF, 23'h0};
                    r.fl = 5'b00101;
                end else begin
                    r.fp = {sg, e8, mf};
                    uf   = (e8 == 8'd0) && (mf != 23'd0);
                    r.fl = {3'b000, uf, nx};
                end
            end
            3'd1: r.fp = {sg, nz};
            3'd2: begin r.fp = {sg, 8'hFF, 23'h0}; r.fl = 5'b00100; end
            3'd3: begin r.fp = 32'h7FFF_FFFF; r.fl = 5'b10000; end
            default: r.fp = 32'h0;
        endcase
        r.fp_sat = (er == 3'd0 && ovf) ? {sg, 8'hFE, 23'h7FFFFF} : r.fp;
        if (r.fl[4])      r.ec = 3'd1;
        else if (r.fl[2]) r.ec = 3'd3;
        else if (r.fl[1]) r.ec = 3'd4;
        else if (r.fl[0]) r.ec = 3'd5;
        else              r.ec = 3'd0;
        return r;
    endfunction

    // Monitor: handshakes seen at the falling edge take effect at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            mflags = '0;
        end else begin
            if (in_valid && in_ready) begin
                sbq.push_back(model(sign_i, exp_i, sig_i, nz_op_i, err_i));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_fp", fp_o, e.fp);
                    chk("sb_fp_sat", fp_s, e.fp_sat);
                    chk("sb_err", err_o, e.ec);
                    chk("sb_err_sat", err_s, e.ec);
                    chk("sb_vld_sat", out_valid_s, 1);
                    chk("sb_flags", flags_o, mflags);
                    chk("sb_flags_sat", flags_s, mflags);
                    mflags = (flags_clr ? 5'b0 : mflags) | e.fl;
                end
                xfer_cnt++;
            end else if (flags_clr) begin
                mflags = '0;
            end
        end
    end

    task automatic send(input logic sg, input logic [7:0] ex, input logic [26:0] sig,
                        input logic [30:0] nz, input logic [2:0] er);
        int n;
        sign_i   = sg;
        exp_i    = ex;
        sig_i    = sig;
        nz_op_i  = nz;
        err_i    = er;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) chk("wait_out_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          a0, x0;
        bit          done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sign_i    = 1'b0;
        exp_i     = '0;
        sig_i     = '0;
        nz_op_i   = '0;
        err_i     = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fp", fp_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_flags", flags_o, 0);
        rst = 1'b0;

        // Tie with even LSB, latency 2
        send(0, 8'h7F, {1'b1, 23'h0, 3'b100}, 0, 3'd0);
        chk("lat_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_2", out_valid, 1);
        chk("tie_fp", fp_o, 32'h3F80_0000);
        chk("tie_err", err_o, 5);
        @(posedge clk);
        #1;
        chk("tie_flags", flags_o, 5'b00001);

        // Rounding carry
        send(0, 8'h7F, {1'b1, 23'h7FFFFF, 3'b110}, 0, 3'd0);
        wait_out();
        chk("carry_fp", fp_o, 32'h4000_0000);
        chk("carry_err", err_o, 5);

        // Overflow by rounding
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 3'd0);
        wait_out();
        chk("ovf_fp", fp_o, 32'h7F80_0000);
        chk("ovf_fp_sat", fp_s, 32'h7F7F_FFFF);
        chk("ovf_err", err_o, 3);
        @(posedge clk);
        #1;
        chk("ovf_flags", flags_o, 5'b00101);

        // NaN
        send(0, 8'h12, 27'h123_4567, 0, 3'd3);
        wait_out();
        chk("nan_fp", fp_o, 32'h7FFF_FFFF);
        chk("nan_err", err_o, 1);
        @(posedge clk);
        #1;
        chk("nan_nv", flags_o[4], 1);

        // ZERO_OP passes the other operand through
        send(1, 8'h00, 27'h0, 31'h4049_0FDB, 3'd1);
        wait_out();
        chk("zop_fp", fp_o, 32'hC049_0FDB);
        chk("zop_err", err_o, 0);

        // Denormals
        send(0, 8'h00, {1'b0, 23'h000001, 3'b000}, 0, 3'd0);
        wait_out();
        chk("den_fp", fp_o, 32'h0000_0001);
        chk("den_err", err_o, 4);
        send(0, 8'h00, {1'b0, 23'h7FFFFF, 3'b110}, 0, 3'd0);
        wait_out();
        chk("den2norm_fp", fp_o, 32'h0080_0000);
        chk("den2norm_err", err_o, 5);
        @(posedge clk);
        #1;

        // Clear coinciding with an NX transfer
        send(0, 8'h7F, {1'b1, 23'h0, 3'b100}, 0, 3'd0);
        wait_out();
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("clr_xfer_flags", flags_o, 5'b00001);

        // Clear without transfer
        send(0, 8'h01, 27'h0, 0, 3'd3);
        wait_out();
        @(posedge clk);
        #1;
        chk("nan_flags", flags_o, 5'b10001);
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("clr_idle_flags", flags_o, 5'b00000);

        // Backpressure: four back-to-back beats against a stalled sink
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(0, 8'h80 + 8'(i), {1'b1, 23'(i * 3 + 1), 3'b001}, 0, 3'd0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepts", acc_cnt - a0, 2);
                held = fp_o;
                @(posedge clk);
                #1;
                chk("bp_fp_stable", fp_o, held);
                chk("bp_out_valid", out_valid, 1);
                x0 = xfer_cnt;
                out_ready = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                chk("bp_drain_4", xfer_cnt - x0, 4);
            end
        join
        drain();

        // Random traffic with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [7:0] ex;
                    logic [2:0] er;
                    case ($urandom_range(0, 4))
                        0: ex = 8'h00;
                        1: ex = 8'hFE;
                        2: ex = 8'hFF;
                        default: ex = 8'($urandom);
                    endcase
                    er = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 4));
                    send(1'($urandom), ex, {(ex != 0) ? 1'b1 : 1'b0, 26'($urandom)},
                         31'($urandom), er);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                    flags_clr = ($urandom_range(0, 7) == 0);
                end
                flags_clr = 1'b0;
            end
        join
        drain();

        // Reset mid-stream with a stalled pipeline and non-zero flags
        send(0, 8'h7F, {1'b1, 23'h0, 3'b100}, 0, 3'd0);
        wait_out();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(0, 8'h80, {1'b1, 23'h5, 3'b000}, 0, 3'd0);
        send(0, 8'h81, {1'b1, 23'h6, 3'b000}, 0, 3'd0);
        chk("pre_rst_flags", flags_o, 5'b00001);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_flags", flags_o, 0);
        chk("rst_mid_fp", fp_o, 0);
        chk("rst_mid_in_ready", in_ready_s, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(0, 8'h7F, {1'b1, 23'h7FFFFF, 3'b110}, 0, 3'd0);
        wait_out();
        chk("post_rst_fp", fp_o, 32'h4000_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
